// File: rtl/text_overlay_pkg.sv
// Banner / FSM state codes shared by the overlay sequencer and the text pixel generator.
// Latency: n/a (constants only).  Backpressure: n/a.
// The RUN/READY/OVER/DONE states reuse the banner codes so show_text can be driven from state directly.
package text_overlay_pkg;

    localparam logic [1:0] TXT_NONE     = 2'b00;
    localparam logic [1:0] TXT_READY    = 2'b01;
    localparam logic [1:0] TXT_OVER     = 2'b10;
    localparam logic [1:0] TXT_COMPLETE = 2'b11;

    localparam logic [1:0] ST_RUN   = TXT_NONE;
    localparam logic [1:0] ST_READY = TXT_READY;
    localparam logic [1:0] ST_OVER  = TXT_OVER;
    localparam logic [1:0] ST_DONE  = TXT_COMPLETE;

    function automatic logic [1:0] banner_code(input logic [1:0] state, input logic blank);
        return (state == ST_READY && blank) ? TXT_NONE : state;
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Registered compare of the VGA counters: one-cycle frame_tick per frame at (0, TICK_LINE).
// Latency: 1 cycle after the counter match.  Backpressure: none (free-running pulse).
module frame_tick_gen #(
    parameter int TICK_LINE = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    output logic       frame_tick
);

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (h_cnt == 10'd0) && (v_cnt == 10'(TICK_LINE));
        end
    end

endmodule

// File: rtl/text_overlay_ctrl.sv
// Text overlay sequencer: picks READY / GAME OVER / COMPLETE banner, owns game_run; optional READY blink under TEXT_BLINK_EN.
// Latency: event pulse -> outputs one cycle after the next frame_tick (changes only in vertical blanking).
// Backpressure: none; events are latched as sticky pending flags until the next frame tick.
module text_overlay_ctrl
    import text_overlay_pkg::*;
#(
    parameter int HOLD_FRAMES  = 180,
    parameter int BLINK_FRAMES = 30,
    parameter int TICK_LINE    = 480
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       start_key,
    input  logic       evt_over,
    input  logic       evt_complete,
    output logic [1:0] show_text,
    output logic       game_run,
    output logic       frame_tick
);

    localparam int HW = $clog2(HOLD_FRAMES + 1);

    generate
        if (HOLD_FRAMES < 1 || BLINK_FRAMES < 1) begin : g_bad_cfg
            $error("text_overlay_ctrl: HOLD_FRAMES and BLINK_FRAMES must be >= 1");
        end
    endgenerate

    logic [1:0]    state, state_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic          pend_start, pend_over, pend_done;
    logic          blank_nxt;

    frame_tick_gen #(.TICK_LINE(TICK_LINE)) u_frame_tick (
        .clk        (clk_25MHz),
        .rst        (rst),
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .frame_tick (frame_tick)
    );

    // Flags clear on the tick but an event in the tick cycle itself survives for the next frame.
    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            pend_start <= 1'b0;
            pend_over  <= 1'b0;
            pend_done  <= 1'b0;
        end else begin
            pend_start <= (pend_start & ~frame_tick) | start_key;
            pend_over  <= (pend_over  & ~frame_tick) | evt_over;
            pend_done  <= (pend_done  & ~frame_tick) | evt_complete;
        end
    end

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        if (frame_tick) begin
            case (state)
                ST_READY: if (pend_start) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (pend_over)      state_nxt = ST_OVER;
                    else if (pend_done) state_nxt = ST_DONE;
                end
                default: begin
                    if (hold_cnt == HW'(HOLD_FRAMES - 1)) state_nxt = ST_READY;
                    else                                  hold_nxt  = hold_cnt + HW'(1);
                end
            endcase
        end
        if (state_nxt != state) hold_nxt = '0;
    end

`ifdef TEXT_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);

    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_off, blink_off_nxt;

    // Phase restarts lit whenever READY is (re)entered.
    always_comb begin
        blink_cnt_nxt = blink_cnt;
        blink_off_nxt = blink_off;
        if (state != ST_READY || state_nxt != ST_READY) begin
            blink_cnt_nxt = '0;
            blink_off_nxt = 1'b0;
        end else if (frame_tick) begin
            if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                blink_cnt_nxt = '0;
                blink_off_nxt = ~blink_off;
            end else begin
                blink_cnt_nxt = blink_cnt + BW'(1);
            end
        end
        blank_nxt = blink_off_nxt;
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else begin
            blink_cnt <= blink_cnt_nxt;
            blink_off <= blink_off_nxt;
        end
    end
`else
    assign blank_nxt = 1'b0;
`endif

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state     <= ST_READY;
            hold_cnt  <= '0;
            show_text <= TXT_READY;
            game_run  <= 1'b0;
        end else begin
            state     <= state_nxt;
            hold_cnt  <= hold_nxt;
            show_text <= banner_code(state_nxt, blank_nxt);
            game_run  <= (state_nxt == ST_RUN);
        end
    end

endmodule

// File: tb/tb_text_overlay_ctrl.sv
// Bench for text_overlay_ctrl: VGA counter model, directed + random event pulses, frame-level reference model and scoreboard.
module tb_text_overlay_ctrl;
    import text_overlay_pkg::*;

    localparam int HOLD  = 3;
    localparam int BLINK = 2;
    localparam int TICK  = 8;
    localparam int H_TOT = 16;
    localparam int V_TOT = 10;
    localparam int FRAME = H_TOT * V_TOT;

    logic       clk_25MHz = 1'b0;
    logic       rst;
    logic [9:0] h_cnt, v_cnt;
    logic       start_key, evt_over, evt_complete;
    logic [1:0] show_text;
    logic       game_run, frame_tick;

    int checks = 0;
    int errors = 0;

    always #5 clk_25MHz = ~clk_25MHz;

    text_overlay_ctrl #(
        .HOLD_FRAMES  (HOLD),
        .BLINK_FRAMES (BLINK),
        .TICK_LINE    (TICK)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .rst          (rst),
        .h_cnt        (h_cnt),
        .v_cnt        (v_cnt),
        .start_key    (start_key),
        .evt_over     (evt_over),
        .evt_complete (evt_complete),
        .show_text    (show_text),
        .game_run     (game_run),
        .frame_tick   (frame_tick)
    );

    // Reference model: frame-level view (tick index since entering a mode, event time windows).
    typedef enum {M_READY, M_RUN, M_OVER, M_DONE} mode_e;
    mode_e mode = M_READY;
    int    tick_num = 0, entry_tick = 0;
    int    cyc = 0, prev_tick_cyc = 0, rst_cyc = -1;
    int    hc = 0, vc = 0;
    bit    m_ft = 1'b0;
    int    start_q[$], over_q[$], comp_q[$];
    logic [3:0] exp_q[$];

    function automatic bit seen(input int q[$], input int lo, input int hi);
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] model_banner(input mode_e m, input int since);
        case (m)
`ifdef TEXT_BLINK_EN
            M_READY: return ((since / BLINK) % 2 == 1) ? TXT_NONE : TXT_READY;
`else
            M_READY: return TXT_READY;
`endif
            M_RUN:   return TXT_NONE;
            M_OVER:  return TXT_OVER;
            default: return TXT_COMPLETE;
        endcase
    endfunction

    task automatic enter(input mode_e m);
        mode       = m;
        entry_tick = tick_num;
    endtask

    task automatic step(input bit s, input bit o, input bit c, input bit r);
        int lo;
        bit ps, po, pc;
        @(negedge clk_25MHz);
        rst = r; start_key = s; evt_over = o; evt_complete = c;
        h_cnt = 10'(hc); v_cnt = 10'(vc);
        if (s) start_q.push_back(cyc);
        if (o) over_q.push_back(cyc);
        if (c) comp_q.push_back(cyc);
        if (r) begin
            enter(M_READY);
            rst_cyc = cyc;
            start_q.delete(); over_q.delete(); comp_q.delete();
            m_ft = 1'b0;
        end else begin
            if (m_ft) begin
                lo = (prev_tick_cyc > rst_cyc) ? prev_tick_cyc : rst_cyc + 1;
                ps = seen(start_q, lo, cyc);
                po = seen(over_q, lo, cyc);
                pc = seen(comp_q, lo, cyc);
                tick_num++;
                case (mode)
                    M_READY: if (ps) enter(M_RUN);
                    M_RUN: begin
                        if (po)      enter(M_OVER);
                        else if (pc) enter(M_DONE);
                    end
                    default: if (tick_num - entry_tick == HOLD) enter(M_READY);
                endcase
                prev_tick_cyc = cyc;
                while (start_q.size() > 0 && start_q[0] < cyc) void'(start_q.pop_front());
                while (over_q.size() > 0 && over_q[0] < cyc) void'(over_q.pop_front());
                while (comp_q.size() > 0 && comp_q[0] < cyc) void'(comp_q.pop_front());
            end
            m_ft = (hc == 0 && vc == TICK);
        end
        exp_q.push_back({model_banner(mode, tick_num - entry_tick), mode == M_RUN, m_ft});
        hc++;
        if (hc == H_TOT) begin
            hc = 0;
            vc = (vc + 1) % V_TOT;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < FRAME + 2 && !m_ft; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every post-edge output against the scoreboard.
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk_25MHz);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({show_text, game_run, frame_tick} !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t show/run/tick got %b/%b/%b want %b/%b/%b",
                             $time, show_text, game_run, frame_tick, e[3:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; start_key = 1'b0; evt_over = 1'b0; evt_complete = 1'b0;
        h_cnt = '0; v_cnt = '0;
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(5 * FRAME);
        // start mid-frame, then both end events together, start during hold
        idle(40);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2 * FRAME);
        idle(30);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(FRAME + 10);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(4 * FRAME);
        // complete only
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2 * FRAME);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle(5 * FRAME);
        // over coincident with the tick, then reset while in OVER
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(2 * FRAME);
        wait_tick();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(FRAME + 20);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(3 * FRAME);
        // random traffic
        for (int i = 0; i < 9000; i++)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 299) == 0,
                 $urandom_range(0, 299) == 0, $urandom_range(0, 2999) == 0);
        repeat (2) @(posedge clk_25MHz);
        #3;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_overlay_ctrl.md
# text_overlay_ctrl

Sequences the full-screen text overlay: decides which banner (READY, GAME OVER, COMPLETE, or none) the text pixel generator draws. It sits between the game logic and the text pixel generator, and drives the generator's 2-bit `show_text` select. Banner changes are applied only at a per-frame tick inside vertical blanking, so a banner never changes mid-frame (no tearing). It also owns the "game running" qualifier that gates the game logic.

## Interface
- `HOLD_FRAMES`, 180: number of frames GAME OVER / COMPLETE stays on screen before returning to READY; must be ≥ 1.
- `BLINK_FRAMES`, 30: number of frames per blink phase of READY (used only with the blink feature); must be ≥ 1.
- `TICK_LINE`, 480: value of `v_cnt` at which the frame tick fires.
- `clk_25MHz` in 1: pixel clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `h_cnt` in 10: current pixel column from the VGA timing generator.
- `v_cnt` in 10: current line from the VGA timing generator.
- `start_key` in 1: one-cycle pulse requesting game start (already debounced).
- `evt_over` in 1: one-cycle pulse from game logic; player lost.
- `evt_complete` in 1: one-cycle pulse from game logic; level cleared.
- `show_text` out 2: banner select. 00 = none, 01 = READY, 10 = GAME OVER, 11 = COMPLETE.
- `game_run` out 1: high only while in the RUN state.
- `frame_tick` out 1: one-cycle pulse per frame, exported for other frame-rate logic.

## Operation
- **Frame tick:** `frame_tick` is high for exactly one cycle when `h_cnt==0 && v_cnt==TICK_LINE`, registered, so it appears one cycle after the match. All state changes happen only on cycles where `frame_tick` is high.
- **Pending flags:** `start_key`, `evt_over` and `evt_complete` each set a sticky pending flag on any cycle. All three flags are cleared on every frame tick, whether or not they were consumed. An event arriving in the same cycle as the tick is kept for the next tick.
- **States:** READY, RUN, OVER, DONE. Encodings equal the `show_text` codes 01, 00, 10, 11.
  - READY: on a tick with start pending → RUN. Other pending events are discarded.
  - RUN: on a tick with over pending → OVER. Otherwise, with complete pending → DONE. If both are pending, OVER wins. Start is ignored.
  - OVER / DONE: the hold counter increments on each tick. On the tick where it equals HOLD_FRAMES-1 → READY. All events are ignored.
- **Hold counter:** width is $clog2(HOLD_FRAMES+1). It is zeroed on every state transition.
- **Outputs:** `show_text` equals the state code, except the READY blink described under Configuration. `game_run = (state==RUN)`.
- **Reset:** state = READY, `show_text` = 01, `game_run` = 0, `frame_tick` = 0, counters = 0, pending flags = 0.
- **Reset mid-operation:** any state returns to READY on the next edge. Pending flags are lost.

## Timing
- Frame tick: a match at cycle c gives `frame_tick` high at c+1.
- Event latency: an event pulse at cycle t gives `show_text` / `game_run` updated one cycle after the first `frame_tick` strictly after t. The update is therefore at most one frame plus 2 cycles after the event.
- OVER / DONE visible duration: exactly HOLD_FRAMES frames, measured tick to tick.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `TEXT_BLINK_EN` defined: in READY, `show_text` alternates 01 / 00 every BLINK_FRAMES ticks. The first phase after entering READY (including after reset) is 01. The blink counter is zeroed on entering READY.
- `TEXT_BLINK_EN` undefined: READY shows a steady 01. The blink counter and its logic are absent.

## Structure
- Shared package `text_overlay_pkg` holds the state/banner code constants: TXT_NONE = 2'b00, TXT_READY = 2'b01, TXT_OVER = 2'b10, TXT_COMPLETE = 2'b11. The text pixel generator uses the same constants.
- Sub-module `frame_tick_gen` contains the registered `h_cnt`/`v_cnt` compare, parameterised by TICK_LINE.
- The top level holds the pending flags, FSM, hold counter and optional blink counter.

## Test plan
Bench parameters: HOLD_FRAMES=3, BLINK_FRAMES=2. The bench drives a short VGA counter model.
- Reset, then 5 frames with no inputs → `show_text`=01 throughout, `game_run`=0, one `frame_tick` per frame.
- `start_key` pulse mid-frame → `show_text`=00 and `game_run`=1 from one cycle after the next tick. Nothing changes before that tick.
- In RUN, `evt_over` and `evt_complete` in the same cycle → `show_text`=10 for exactly 3 frames, then 01. `start_key` pulsed during the hold is ignored.
- In RUN, `evt_complete` only → 11 for 3 frames, then 01. `game_run`=0 from entry to DONE onward.
- `evt_over` coincident with the `frame_tick` cycle → transition occurs at the following tick, not the current one. `rst` asserted while in OVER → next cycle `show_text`=01, `game_run`=0.
- With `TEXT_BLINK_EN` defined, idle in READY → `show_text` sequence per frame is 01,01,00,00,01,… Without `TEXT_BLINK_EN` → constant 01.
